// File: rtl/mult_acc_if.sv
// Handshake bundle between the multiplier front end and the mult_acc accumulator.
// master: upstream/downstream side (drives terms, takes results); slave: the accumulator.
interface mult_acc_if #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned GUARD = 4,
  parameter int unsigned CNT_W = 4
);
  localparam int unsigned ACC_W = 2 * SIZE + GUARD;

  logic             in_valid;
  logic             in_ready;
  logic [SIZE-1:0]  hm;
  logic [SIZE-1:0]  lm;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  modport master (
    output in_valid, hm, lm, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, hm, lm, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/mult_acc.sv
// mult_acc: sums a run of {hm,lm} product terms and presents total, term count and a
// sticky overflow flag on a valid/ready result port. One bubble cycle between runs.
// Build option: define MULT_ACC_SAT_EN to clamp the accumulator at all-ones on overflow
// instead of wrapping modulo 2^ACC_W.
module mult_acc #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned GUARD = 4,
  parameter int unsigned CNT_W = 4
) (
  input logic       clk,
  input logic       rst,
  mult_acc_if.slave bus
);
  localparam int unsigned ACC_W = 2 * SIZE + GUARD;

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             last_term;

  // Next accumulator value, carry out and end-of-run detection for the offered term.
  always_comb begin
    accept    = bus.in_valid & in_ready_q;
    sum_ext   = {1'b0, acc_q} + (ACC_W + 1)'({bus.hm, bus.lm});
    carry     = sum_ext[ACC_W];
`ifdef MULT_ACC_SAT_EN
    // Once clamped, every later add carries again, so the clamp persists for the run.
    acc_d     = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_d     = sum_ext[ACC_W-1:0];
`endif
    cnt_d     = cnt_q + 1'b1;
    // A full counter closes the run even without in_last, so cnt can never wrap.
    last_term = bus.in_last | (cnt_d == '1);
  end

  // Run-control FSM; in_ready/out_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StAccum: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_q | carry;
            if (last_term) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StHold: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_mult_acc.sv
// Bench for mult_acc: default instance (ACC_W=12) driven from a vector table plus corner
// sequences with a result scoreboard; a GUARD=0 instance (ACC_W=8) for overflow behaviour.
module tb_mult_acc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_acc_if #(.SIZE(4), .GUARD(4), .CNT_W(4)) bus_a ();
  mult_acc_if #(.SIZE(4), .GUARD(0), .CNT_W(4)) bus_b ();

  mult_acc #(.SIZE(4), .GUARD(4), .CNT_W(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  mult_acc #(.SIZE(4), .GUARD(0), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  hm;
    logic [3:0]  lm;
    logic        last;
    logic [11:0] sum;
    logic [3:0]  cnt;
    int          hold;
  } vec_t;

  typedef struct {
    logic [11:0] sum;
    logic [3:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t        sbq[$];
  int unsigned m_sum = 0;
  int unsigned m_cnt = 0;
  bit          m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model for the 12-bit instance; pushes a result when a run closes.
  task automatic model_term(input logic [3:0] h, input logic [3:0] l, input logic last);
    m_sum += {24'd0, h, l};
    if (m_sum >= 4096) begin
      m_ovf = 1'b1;
`ifdef MULT_ACC_SAT_EN
      m_sum = 4095;
`else
      m_sum -= 4096;
`endif
    end
    m_cnt++;
    if (last || m_cnt == 15) begin
      sbq.push_back('{sum: m_sum[11:0], cnt: m_cnt[3:0], ovf: m_ovf});
      m_sum = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic send_a(input logic [3:0] h, input logic [3:0] l, input logic last);
    int w = 0;
    while (!bus_a.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus_a.in_ready) chk("in_ready_timeout", 32'(bus_a.in_ready), 32'd1);
    bus_a.hm       = h;
    bus_a.lm       = l;
    bus_a.in_last  = last;
    bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
    model_term(h, l, last);
  endtask

  // Holds the result for hold cycles with out_ready low, then releases it.
  task automatic release_a(input int hold, input logic [11:0] s, input logic [3:0] c);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_sum", 32'(bus_a.out_sum), 32'(s));
      chk("hold_count", 32'(bus_a.out_count), 32'(c));
      chk("hold_valid", 32'(bus_a.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus_a.in_ready), 32'd0);
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0;
    chk("rel_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rel_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("rel_sum", 32'(bus_a.out_sum), 32'd0);
    chk("rel_count", 32'(bus_a.out_count), 32'd0);
  endtask

  // Scoreboard: compare each result at its output handshake.
  always @(negedge clk) begin
    if (!rst && bus_a.out_valid && bus_a.out_ready) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_sum", 32'(bus_a.out_sum), 32'(e.sum));
        chk("sb_count", 32'(bus_a.out_count), 32'(e.cnt));
        chk("sb_ovf", 32'(bus_a.out_ovf), 32'(e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    logic [7:0] ovf_sum;
    vecs[0] = '{hm: 4'h0, lm: 4'hF, last: 1'b0, sum: 12'h00F, cnt: 4'd1, hold: 0};
    vecs[1] = '{hm: 4'h0, lm: 4'hE, last: 1'b0, sum: 12'h01D, cnt: 4'd2, hold: 0};
    vecs[2] = '{hm: 4'hE, lm: 4'h1, last: 1'b1, sum: 12'h0FE, cnt: 4'd3, hold: 5};
    vecs[3] = '{hm: 4'hF, lm: 4'hF, last: 1'b0, sum: 12'h0FF, cnt: 4'd1, hold: 0};
    vecs[4] = '{hm: 4'hF, lm: 4'hF, last: 1'b1, sum: 12'h1FE, cnt: 4'd2, hold: 1};

    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.hm = '0; bus_a.lm = '0; bus_a.in_last = 1'b0;
    bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.hm = '0; bus_b.lm = '0; bus_b.in_last = 1'b0;
    bus_b.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("rst_sum", 32'(bus_a.out_sum), 32'd0);
    chk("rst_count", 32'(bus_a.out_count), 32'd0);
    chk("rst_ovf", 32'(bus_a.out_ovf), 32'd0);

    // Table runs: basic run with backpressure, then a second run.
    for (int i = 0; i < 5; i++) begin
      send_a(vecs[i].hm, vecs[i].lm, vecs[i].last);
      chk("vec_sum", 32'(bus_a.out_sum), 32'(vecs[i].sum));
      chk("vec_count", 32'(bus_a.out_count), 32'(vecs[i].cnt));
      chk("vec_valid", 32'(bus_a.out_valid), 32'(vecs[i].last));
      chk("vec_ovf", 32'(bus_a.out_ovf), 32'd0);
      if (vecs[i].last) release_a(vecs[i].hold, vecs[i].sum, vecs[i].cnt);
    end

    // Implicit last after 15 terms.
    for (int i = 0; i < 15; i++) begin
      send_a(4'h0, 4'h1, 1'b0);
      chk("impl_count", 32'(bus_a.out_count), 32'(i + 1));
      chk("impl_valid", 32'(bus_a.out_valid), (i == 14) ? 32'd1 : 32'd0);
    end
    chk("impl_sum", 32'(bus_a.out_sum), 32'd15);
    release_a(2, 12'd15, 4'd15);

    // Reset mid-run discards the partial run.
    send_a(4'h3, 4'h3, 1'b0);
    send_a(4'h2, 4'h2, 1'b0);
    m_sum = 0; m_cnt = 0; m_ovf = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_sum", 32'(bus_a.out_sum), 32'd0);
    chk("mid_rst_count", 32'(bus_a.out_count), 32'd0);
    chk("mid_rst_in_ready", 32'(bus_a.in_ready), 32'd1);
    send_a(4'h0, 4'h1, 1'b1);
    chk("post_rst_sum", 32'(bus_a.out_sum), 32'd1);
    chk("post_rst_count", 32'(bus_a.out_count), 32'd1);
    chk("post_rst_valid", 32'(bus_a.out_valid), 32'd1);
    release_a(0, 12'd1, 4'd1);

    // Overflow on the 8-bit accumulator: 225 + 225.
`ifdef MULT_ACC_SAT_EN
    ovf_sum = 8'hFF;
`else
    ovf_sum = 8'hC2;
`endif
    bus_b.hm = 4'hE; bus_b.lm = 4'h1; bus_b.in_last = 1'b0; bus_b.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("ovf_first_sum", 32'(bus_b.out_sum), 32'h0E1);
    chk("ovf_first_flag", 32'(bus_b.out_ovf), 32'd0);
    bus_b.in_last = 1'b1;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
    chk("ovf_valid", 32'(bus_b.out_valid), 32'd1);
    chk("ovf_sum", 32'(bus_b.out_sum), 32'(ovf_sum));
    chk("ovf_flag", 32'(bus_b.out_ovf), 32'd1);
    chk("ovf_count", 32'(bus_b.out_count), 32'd2);
    bus_b.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_b.out_ready = 1'b0;
    chk("ovf_clr_flag", 32'(bus_b.out_ovf), 32'd0);
    chk("ovf_clr_sum", 32'(bus_b.out_sum), 32'd0);

    repeat (2) @(posedge clk); #1;
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
